sdhci_crc_lanes: RTL and testbench
==================================

# sdhci_crc_lanes

Parametrised multi-lane serial CRC engine for the SDHCI command and data paths. Generates CRC7 for the CMD line or CRC16 for 1/4/8 DAT lanes, one independent CRC per lane. A frame FSM counts payload bits and then shifts the CRC out MSb first. Optionally, it checks received CRC bits against the computed value for the read path.

## Interface
- `CRC_WIDTH`, default 16: CRC register width per lane (7 for CMD, 16 for DAT).
- `POLY`, default 16'h1021: generator polynomial without the x^CRC_WIDTH term (7'h09 for CRC7).
- `NUM_LANES`, default 4: number of parallel serial lanes (1, 4 or 8).
- `LEN_WIDTH`, default 13: width of the payload bit counter.
- `clk_i`  in  1  clock, single clock domain.
- `rst_i`  in  1  reset, synchronous, active-high.
- `start_i`  in  1  pulse; begins a frame; sampled only in IDLE.
- `mode_i`  in  1  0 = generate, 1 = check; sampled with start_i.
- `len_i`  in  LEN_WIDTH  payload bits per lane; sampled with start_i.
- `step_i`  in  1  bit enable; one payload or CRC bit per asserted cycle.
- `dat_i`  in  NUM_LANES  serial payload bit per lane (check mode: also received CRC bits).
- `busy_o`  out  1  high outside IDLE.
- `crc_valid_o`  out  1  high while in SHIFT (crc_o meaningful).
- `crc_o`  out  NUM_LANES  current CRC bit per lane, MSb first.
- `crc_par_o`  out  NUM_LANES*CRC_WIDTH  lane registers, lane 0 in the LSBs.
- `done_o`  out  1  single-cycle pulse at frame end.
- `crc_err_o`  out  NUM_LANES  sticky per-lane mismatch; valid from done_o until the next start_i.

## Operation
FSM states are IDLE, CALC, SHIFT and CHECK.

- **IDLE**
  - On start_i: clear all lane registers to zero, clear crc_err_o, load the bit counter with len_i, latch mode_i.
  - Next state is CALC, or directly SHIFT/CHECK (per mode) when len_i == 0.
- **CALC**
  - Each step_i cycle, every lane updates: fb = dat_i[l] ^ reg[MSb]; reg = (reg << 1) ^ (fb ? POLY : 0).
  - The counter decrements on each step_i. The cycle that consumes the last bit moves to SHIFT (mode 0) or CHECK (mode 1).
- **SHIFT**
  - crc_o[l] = reg[l][CRC_WIDTH-1], combinational from the register.
  - Each step_i cycle: reg <<= 1 with zero fill; the shift counter decrements from CRC_WIDTH.
  - After the CRC_WIDTH-th step: pulse done_o, return to IDLE.
- **CHECK**
  - Each step_i cycle: crc_err_o[l] |= dat_i[l] ^ reg[l][MSb]; reg <<= 1.
  - After CRC_WIDTH steps: pulse done_o, return to IDLE.
- Lanes are fully independent. There is no cross-lane arithmetic.
- step_i low means hold: no register, counter or state change.
- start_i outside IDLE is ignored.
- crc_par_o reflects the live registers. It holds the full CRC on the cycle after CALC exits.

## Timing
- Reset values: all lane registers 0; state IDLE; busy_o, crc_valid_o, done_o, crc_o and crc_err_o all 0.
- start_i in cycle N gives busy_o = 1 in cycle N+1. step_i in cycle N is ignored when start_i is also accepted in N.
- A frame takes exactly len_i + CRC_WIDTH step_i cycles after start.
- The first CRC bit is on crc_o in the cycle after the last payload step; no extra step is needed.
- done_o is asserted in the cycle after the final CRC step, together with busy_o = 0. A new start_i is accepted in that same cycle.
- crc_valid_o drops in the same cycle as done_o.
- rst_i mid-frame: next cycle is IDLE, registers are zero, and no done_o is produced.
- Counter wrap: len_i is at most 2^LEN_WIDTH-1. The counter never wraps; it is checked for 1 before decrementing.

## Configuration
- `SDHCI_CRC_CHECK_EN` defined: CHECK state and crc_err_o logic are present; mode_i = 1 selects check.
- Not defined:
  - mode_i is ignored and treated as 0.
  - CHECK is absent.
  - crc_err_o is tied to 0.

## Structure
- Package `sdhci_crc_pkg`:
  - FSM state enum `crc_state_e`.
  - Constants `CRC7_POLY` = 7'h09 and `CRC16_POLY` = 16'h1021.
  - Widths `CRC7_W` and `CRC16_W`.
- Sub-module `sdhci_crc_lane`, instantiated NUM_LANES times. It holds one CRC register with three controls: clear, compute-step and shift-step. The FSM and counters stay in the top.

## Test plan
- CRC7 (CRC_WIDTH 7, POLY 7'h09, NUM_LANES 1), CMD0 payload 40 00 00 00 00, len_i 40 → crc_o serial 1001010 (0x4A), done_o after 47 steps.
- CRC16 with 4 lanes, each lane 512 bytes of 0xFF, len_i 4096 → every lane shifts 0x7FA1; crc_par_o = {4{16'h7FA1}}.
- Check mode, same data, received CRC 0x7FA1 on lanes 0, 1, 3 and 0x7FA0 on lane 2 → crc_err_o = 4'b0100 at done_o.
- len_i 0 → SHIFT entered the cycle after start; crc_o = 0 for 16 steps; done_o follows.
- step_i gapped (1 in 3 cycles) vs continuous → identical CRC bits. start_i while busy → ignored.
- rst_i asserted after 8 CRC bits → busy_o 0 next cycle, no done_o. A new frame then yields the correct CRC.

Source files
------------

// File: rtl/sdhci_crc_pkg.sv
// Shared types and constants for the SDHCI multi-lane CRC engine.
// Optional feature macro used by the engine: SDHCI_CRC_CHECK_EN.
package sdhci_crc_pkg;

    // Frame sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_CHECK = 2'd3
    } crc_state_e;

    // CRC7 protects the CMD line, CRC16 protects each DAT line
    localparam int          CRC7_W     = 7;
    localparam int          CRC16_W    = 16;
    localparam logic [6:0]  CRC7_POLY  = 7'h09;
    localparam logic [15:0] CRC16_POLY = 16'h1021;

endpackage

// File: rtl/sdhci_crc_lanes_if.sv
// Control/data bundle between a frame producer (master) and the CRC engine (slave).
interface sdhci_crc_lanes_if #(
    parameter int NUM_LANES = 4,
    parameter int CRC_WIDTH = 16,
    parameter int LEN_WIDTH = 13
);
    logic                           start_i;
    logic                           mode_i;
    logic [LEN_WIDTH-1:0]           len_i;
    logic                           step_i;
    logic [NUM_LANES-1:0]           dat_i;
    logic                           busy_o;
    logic                           crc_valid_o;
    logic [NUM_LANES-1:0]           crc_o;
    logic [NUM_LANES*CRC_WIDTH-1:0] crc_par_o;
    logic                           done_o;
    logic [NUM_LANES-1:0]           crc_err_o;

    modport master (
        output start_i, mode_i, len_i, step_i, dat_i,
        input  busy_o, crc_valid_o, crc_o, crc_par_o, done_o, crc_err_o
    );

    modport slave (
        input  start_i, mode_i, len_i, step_i, dat_i,
        output busy_o, crc_valid_o, crc_o, crc_par_o, done_o, crc_err_o
    );
endinterface

// File: rtl/sdhci_crc_lane.sv
// One serial CRC register: clear, LFSR compute step, or plain shift-out step.
module sdhci_crc_lane #(
    parameter int                   CRC_WIDTH = 16,
    parameter logic [CRC_WIDTH-1:0] POLY      = CRC_WIDTH'(16'h1021)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clear_i,
    input  logic                 calc_i,
    input  logic                 shift_i,
    input  logic                 dat_i,
    output logic [CRC_WIDTH-1:0] crc_q_o
);

    logic [CRC_WIDTH-1:0] reg_q;
    logic [CRC_WIDTH-1:0] reg_d;
    logic                 fb;

    // Next register value; clear wins over compute, compute over shift
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        reg_d = reg_q;
        fb    = dat_i ^ reg_q[CRC_WIDTH-1];
        if (clear_i) begin
            reg_d = '0;
        end else if (calc_i) begin
            reg_d = (reg_q << 1) ^ (fb ? POLY : '0);
        end else if (shift_i) begin
            reg_d = reg_q << 1;
        end
    end

    // CRC register with synchronous reset
    always_ff @(posedge clk_i) begin
        // NOTE: state flops use non-blocking assignments so all flops update from pre-edge values.
        if (rst_i) begin
            reg_q <= '0;
        end else begin
            reg_q <= reg_d;
        end
    end

    assign crc_q_o = reg_q;

endmodule

// File: rtl/sdhci_crc_lanes.sv
// Multi-lane serial CRC engine (CRC7 on CMD, CRC16 on 1/4/8 DAT lanes).
// Frame sequencer counts payload bits, then shifts each lane CRC out MSb first.
// Define SDHCI_CRC_CHECK_EN to add the receive-side CRC compare (CHECK state, crc_err_o).
module sdhci_crc_lanes
    import sdhci_crc_pkg::*;
#(
    parameter int                   CRC_WIDTH = CRC16_W,
    parameter logic [CRC_WIDTH-1:0] POLY      = CRC_WIDTH'(CRC16_POLY),
    parameter int                   NUM_LANES = 4,
    parameter int                   LEN_WIDTH = 13
) (
    input  logic              clk_i,
    input  logic              rst_i,
    sdhci_crc_lanes_if.slave  bus
);

    localparam int SC_W = $clog2(CRC_WIDTH + 1);

    crc_state_e           state_q, state_d;
    logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
    logic [SC_W-1:0]      sh_cnt_q, sh_cnt_d;
    logic                 done_q, done_d;
`ifdef SDHCI_CRC_CHECK_EN
    logic                 mode_q, mode_d;
    logic [NUM_LANES-1:0] err_q, err_d;
`endif

    logic                 lane_clear;
    logic                 lane_calc;
    logic                 lane_shift;
    logic [CRC_WIDTH-1:0] lane_reg [NUM_LANES];
    logic [NUM_LANES-1:0] lane_msb;

    // Per-lane CRC registers; lanes never interact
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        sdhci_crc_lane #(
            .CRC_WIDTH (CRC_WIDTH),
            .POLY      (POLY)
        ) u_lane (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .clear_i (lane_clear),
            .calc_i  (lane_calc),
            .shift_i (lane_shift),
            .dat_i   (bus.dat_i[l]),
            .crc_q_o (lane_reg[l])
        );
        assign lane_msb[l] = lane_reg[l][CRC_WIDTH-1];
        assign bus.crc_par_o[l*CRC_WIDTH +: CRC_WIDTH] = lane_reg[l];
    end

    // Frame sequencer: next state, counters and lane controls
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sh_cnt_d   = sh_cnt_q;
        done_d     = 1'b0;
        lane_clear = 1'b0;
        lane_calc  = 1'b0;
        lane_shift = 1'b0;
`ifdef SDHCI_CRC_CHECK_EN
        mode_d     = mode_q;
        err_d      = err_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                // step_i is deliberately ignored on the start cycle
                if (bus.start_i) begin
                    lane_clear = 1'b1;
                    cnt_d      = bus.len_i;
                    sh_cnt_d   = SC_W'(CRC_WIDTH);
`ifdef SDHCI_CRC_CHECK_EN
                    mode_d     = bus.mode_i;
                    err_d      = '0;
                    if (bus.len_i == '0) state_d = bus.mode_i ? ST_CHECK : ST_SHIFT;
                    else                 state_d = ST_CALC;
`else
                    state_d    = (bus.len_i == '0) ? ST_SHIFT : ST_CALC;
`endif
                end
            end
            ST_CALC: begin
                if (bus.step_i) begin
                    lane_calc = 1'b1;
                    // Compare against 1 before decrementing so the counter never wraps
                    if (cnt_q == LEN_WIDTH'(1)) begin
`ifdef SDHCI_CRC_CHECK_EN
                        state_d = mode_q ? ST_CHECK : ST_SHIFT;
`else
                        state_d = ST_SHIFT;
`endif
                    end
                    cnt_d = cnt_q - LEN_WIDTH'(1);
                end
            end
            ST_SHIFT: begin
                if (bus.step_i) begin
                    lane_shift = 1'b1;
                    if (sh_cnt_q == SC_W'(1)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                    sh_cnt_d = sh_cnt_q - SC_W'(1);
                end
            end
`ifdef SDHCI_CRC_CHECK_EN
            ST_CHECK: begin
                if (bus.step_i) begin
                    lane_shift = 1'b1;
                    err_d      = err_q | (bus.dat_i ^ lane_msb);
                    if (sh_cnt_q == SC_W'(1)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                    sh_cnt_d = sh_cnt_q - SC_W'(1);
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Sequencer registers; reset also suppresses any pending done pulse
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            sh_cnt_q <= '0;
            done_q   <= 1'b0;
`ifdef SDHCI_CRC_CHECK_EN
            mode_q   <= 1'b0;
            err_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sh_cnt_q <= sh_cnt_d;
            done_q   <= done_d;
`ifdef SDHCI_CRC_CHECK_EN
            mode_q   <= mode_d;
            err_q    <= err_d;
`endif
        end
    end

    assign bus.busy_o      = (state_q != ST_IDLE);
    assign bus.crc_valid_o = (state_q == ST_SHIFT);
    assign bus.crc_o       = (state_q == ST_SHIFT) ? lane_msb : '0;
    assign bus.done_o      = done_q;
`ifdef SDHCI_CRC_CHECK_EN
    assign bus.crc_err_o   = err_q;
`else
    assign bus.crc_err_o   = '0;
`endif

endmodule

// File: tb/tb_sdhci_crc_lanes.sv
// Self-checking bench: CRC7 single-lane instance plus CRC16 four-lane instance.
// The four-lane instance is tracked every cycle by a polynomial-division model.
module tb_sdhci_crc_lanes;

`ifdef SDHCI_CRC_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    bit   cmp_en;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    sdhci_crc_lanes_if #(.NUM_LANES(1), .CRC_WIDTH(7),  .LEN_WIDTH(13)) if7  ();
    sdhci_crc_lanes_if #(.NUM_LANES(4), .CRC_WIDTH(16), .LEN_WIDTH(13)) if16 ();

    sdhci_crc_lanes #(
        .CRC_WIDTH (7),
        .POLY      (7'h09),
        .NUM_LANES (1),
        .LEN_WIDTH (13)
    ) u_dut7 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (if7.slave)
    );

    sdhci_crc_lanes #(
        .CRC_WIDTH (16),
        .POLY      (16'h1021),
        .NUM_LANES (4),
        .LEN_WIDTH (13)
    ) u_dut16 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (if16.slave)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Textbook mod-2 long division: remainder of M(x)*x^w divided by G(x)
    function automatic logic [15:0] crc_div(input bit msg[$], input int w, input logic [16:0] gen);
        bit          a[$];
        logic [15:0] r;
        a = msg;
        for (int j = 0; j < w; j++) a.push_back(1'b0);
        for (int i = 0; i < msg.size(); i++) begin
            if (a[i]) begin
                for (int j = 0; j <= w; j++) a[i+j] = a[i+j] ^ gen[w-j];
            end
        end
        r = '0;
        for (int j = 0; j < w; j++) r[w-1-j] = a[msg.size()+j];
        return r;
    endfunction

    function automatic bit pat_bit(input int pat, input int lane, input int idx);
        case (pat)
            0:       return 1'b1;
            1:       return ((idx*5 + lane*3 + (idx >> 2)) % 7) < 3;
            default: return ((idx ^ (lane*11)) & 4) != 0;
        endcase
    endfunction

    // ---------------- reference model for the four-lane instance ----------------
    bit          m_active;
    int          m_pay_left;
    int          m_crc_left;
    bit          m_check;
    bit          m_done;
    logic [3:0]  m_err;
    logic [15:0] m_crc  [4];
    bit          m_bits [4][$];

    always @(posedge clk) begin
        if (rst) begin
            m_active = 1'b0;
            m_done   = 1'b0;
            m_err    = '0;
            for (int l = 0; l < 4; l++) begin
                m_crc[l] = '0;
                m_bits[l].delete();
            end
        end else begin
            m_done = 1'b0;
            if (!m_active) begin
                if (if16.start_i) begin
                    m_active   = 1'b1;
                    m_pay_left = int'(if16.len_i);
                    m_crc_left = 16;
                    m_check    = CHECK_EN && if16.mode_i;
                    m_err      = '0;
                    for (int l = 0; l < 4; l++) begin
                        m_crc[l] = '0;
                        m_bits[l].delete();
                    end
                end
            end else if (if16.step_i) begin
                if (m_pay_left > 0) begin
                    for (int l = 0; l < 4; l++) m_bits[l].push_back(if16.dat_i[l]);
                    m_pay_left--;
                    if (m_pay_left == 0) begin
                        for (int l = 0; l < 4; l++) m_crc[l] = crc_div(m_bits[l], 16, 17'h11021);
                    end
                end else begin
                    if (m_check) begin
                        for (int l = 0; l < 4; l++)
                            m_err[l] = m_err[l] | (if16.dat_i[l] ^ m_crc[l][m_crc_left-1]);
                    end
                    m_crc_left--;
                    if (m_crc_left == 0) begin
                        m_active = 1'b0;
                        m_done   = 1'b1;
                    end
                end
            end
        end
    end

    // Every-cycle compare of the four-lane instance against the model
    always @(negedge clk) begin
        logic [3:0]  exp_crc;
        logic [63:0] exp_par;
        bit          tail;
        if (cmp_en) begin
            tail = m_active && (m_pay_left == 0);
            for (int l = 0; l < 4; l++) begin
                exp_crc[l] = (tail && !m_check) ? m_crc[l][m_crc_left-1] : 1'b0;
                exp_par[l*16 +: 16] = tail ? (m_crc[l] << (16 - m_crc_left)) : 16'h0;
            end
            check("busy",      if16.busy_o,      m_active);
            check("crc_valid", if16.crc_valid_o, tail && !m_check);
            check("done",      if16.done_o,      m_done);
            check("crc_o",     if16.crc_o,       exp_crc);
            check("crc_err",   if16.crc_err_o,   CHECK_EN ? m_err : 4'h0);
            if (!m_active || tail) check("crc_par", if16.crc_par_o, exp_par);
        end
    end

    // ---------------- stimulus ----------------
    logic [15:0] rx16  [4];
    logic [15:0] got16 [4];
    logic [63:0] par_first;
    logic        valid_first;
    logic [3:0]  err_at_done;

    task automatic run16(input int len, input int pat, input bit mode, input int gap, input int abort_at);
        if16.start_i = 1'b1;
        if16.len_i   = 13'(len);
        if16.mode_i  = mode;
        if16.step_i  = 1'b1;
        if16.dat_i   = 4'hF;
        @(posedge clk); #1;
        if16.start_i = 1'b0;
        if16.step_i  = 1'b0;
        for (int l = 0; l < 4; l++) got16[l] = '0;
        for (int k = 0; k < len + 16; k++) begin
            for (int g = 1; g < gap; g++) begin
                if16.step_i  = 1'b0;
                if16.dat_i   = 4'($urandom);
                if16.start_i = (k == 3 && g == 1);
                @(posedge clk); #1;
                if16.start_i = 1'b0;
            end
            if (abort_at >= 0 && k == len + abort_at) begin
                rst          = 1'b1;
                if16.step_i  = 1'b0;
                @(posedge clk); #1;
                rst = 1'b0;
                @(negedge clk);
                check("abort_busy", if16.busy_o, 1'b0);
                check("abort_done", if16.done_o, 1'b0);
                @(posedge clk); #1;
                @(negedge clk);
                check("abort_no_done", if16.done_o, 1'b0);
                @(posedge clk); #1;
                return;
            end
            if16.step_i = 1'b1;
            for (int l = 0; l < 4; l++)
                if16.dat_i[l] = (k < len) ? pat_bit(pat, l, k)
                              : (mode ? rx16[l][15-(k-len)] : 1'($urandom));
            @(negedge clk);
            if (k == len) begin
                par_first   = if16.crc_par_o;
                valid_first = if16.crc_valid_o;
            end
            if (k >= len)
                for (int l = 0; l < 4; l++) got16[l] = {got16[l][14:0], if16.crc_o[l]};
            @(posedge clk); #1;
        end
        if16.step_i = 1'b0;
        @(negedge clk);
        check("done16_pulse", if16.done_o, 1'b1);
        err_at_done = if16.crc_err_o;
        @(posedge clk); #1;
    endtask

    task automatic run7(output logic [6:0] crc, output int steps);
        logic [39:0] pl;
        bit          seen;
        pl   = 40'h40_0000_0000;
        seen = 1'b0;
        if7.start_i = 1'b1;
        if7.len_i   = 13'd40;
        @(posedge clk); #1;
        if7.start_i = 1'b0;
        crc   = '0;
        steps = 0;
        for (int c = 0; c < 100 && !seen; c++) begin
            if7.step_i   = 1'b1;
            if7.dat_i[0] = (steps < 40) ? pl[39-steps] : 1'b1;
            @(negedge clk);
            if (if7.done_o) seen = 1'b1;
            else begin
                if (if7.crc_valid_o) crc = {crc[5:0], if7.crc_o[0]};
                steps++;
            end
            @(posedge clk); #1;
        end
        if7.step_i = 1'b0;
        check("dut7_done_seen", seen, 1'b1);
    endtask

    initial begin
        bit          q[$];
        logic [6:0]  crc7;
        int          steps7;
        logic [15:0] cont [4];

        n_checks = 0;
        n_errors = 0;
        cmp_en   = 1'b0;
        rst      = 1'b1;
        {if7.start_i, if7.mode_i, if7.step_i}    = '0;
        if7.len_i = '0;
        if7.dat_i = '0;
        {if16.start_i, if16.mode_i, if16.step_i} = '0;
        if16.len_i = '0;
        if16.dat_i = '0;
        @(posedge clk); #1;
        cmp_en = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_busy16",  if16.busy_o,      1'b0);
        check("rst_valid16", if16.crc_valid_o, 1'b0);
        check("rst_done16",  if16.done_o,      1'b0);
        check("rst_crc16",   if16.crc_o,       4'h0);
        check("rst_err16",   if16.crc_err_o,   4'h0);
        check("rst_par16",   if16.crc_par_o,   64'h0);
        check("rst_busy7",   if7.busy_o,       1'b0);
        @(posedge clk); #1;

        // Pin the division model to known SD CRC values
        q.delete();
        for (int i = 39; i >= 0; i--) q.push_back(i == 38);
        check("model_crc7_cmd0", crc_div(q, 7, 17'h89), 16'h004A);
        q.delete();
        for (int i = 0; i < 4096; i++) q.push_back(1'b1);
        check("model_crc16_ff", crc_div(q, 16, 17'h11021), 16'h7FA1);

        // CRC7 on CMD0
        run7(crc7, steps7);
        check("crc7_cmd0", crc7, 7'b1001010);
        check("crc7_steps", steps7, 47);

        // CRC16, 512 bytes of 0xFF on each of four lanes
        for (int l = 0; l < 4; l++) rx16[l] = 16'h7FA1;
        rx16[2] = 16'h7FA0;
        run16(4096, 0, 1'b0, 1, -1);
        for (int l = 0; l < 4; l++) check("crc16_ff_serial", got16[l], 16'h7FA1);
        check("crc16_ff_par", par_first, {4{16'h7FA1}});

        // Receive-side compare (or mode ignored when the compare is not built)
        if (CHECK_EN) begin
            run16(4096, 0, 1'b1, 1, -1);
            check("check_err", err_at_done, 4'b0100);
        end else begin
            run16(24, 1, 1'b1, 1, -1);
            check("mode_ignored_err", err_at_done, 4'b0000);
            check("mode_ignored_valid", valid_first, 1'b1);
        end

        // Empty payload: straight to shift-out of an all-zero CRC
        run16(0, 0, 1'b0, 1, -1);
        check("len0_valid_first", valid_first, 1'b1);
        for (int l = 0; l < 4; l++) check("len0_crc", got16[l], 16'h0000);

        // Continuous vs gapped stepping (gapped run also pokes start_i while busy)
        run16(37, 1, 1'b0, 1, -1);
        for (int l = 0; l < 4; l++) cont[l] = got16[l];
        run16(37, 1, 1'b0, 3, -1);
        for (int l = 0; l < 4; l++) check("gap_vs_cont", got16[l], cont[l]);

        // Reset after 8 CRC bits, then a clean frame
        run16(37, 2, 1'b0, 1, 8);
        run16(37, 2, 1'b0, 1, -1);
        for (int l = 0; l < 4; l++) begin
            q.delete();
            for (int k = 0; k < 37; k++) q.push_back(pat_bit(2, l, k));
            check("after_abort_crc", got16[l], crc_div(q, 16, 17'h11021));
        end

        repeat (2) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
